// File: rtl/pwm_dac_driver.sv
// pwm_dac_driver: period-aligned PWM driver with a one-deep sample buffer, period_start pulse and sticky underrun flag
module pwm_dac_driver #(
  parameter int WIDTH = 8,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             underrun_clr,
  output logic             pwm_out,
  output logic             period_start,
  output logic             underrun
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
  logic [PW-1:0] pre_cnt;
  logic [WIDTH-1:0] cnt, duty, hold;
  logic hold_full, tick, bnd;
  assign tick = pre_cnt == PMAX;
  assign bnd = tick && &cnt;
  assign din_ready = ~hold_full;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pre_cnt <= '0;
      cnt <= '0;
      duty <= '0;
      hold <= '0;
      hold_full <= 1'b0;
      underrun <= 1'b0;
      pwm_out <= 1'b0;
      period_start <= 1'b0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      cnt <= tick ? cnt + 1'b1 : cnt;
      if (bnd && hold_full) begin
        duty <= hold;
        hold_full <= 1'b0;
      end else if (din_valid && !hold_full) begin
        hold <= din;
        hold_full <= 1'b1;
      end
      underrun <= (bnd && !hold_full) || (underrun && !underrun_clr);
      pwm_out <= cnt < duty;
      period_start <= bnd;
    end
endmodule

// File: tb/tb_pwm_dac_driver.sv
// tb_pwm_dac_driver: random and directed checks of two pwm_dac_driver configurations against an arithmetic model
module tb_pwm_dac_driver;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] dv = '0, clr = '0, rdy, pwm, ps, ur;
  logic [7:0] d0 = '0;
  logic [3:0] d1 = '0;
  int checks = 0, errs = 0;
  int m_duty[2], m_hold[2], pos[2];
  bit m_full[2], m_under[2], m_pwm[2], m_ps[2];

  always #5 clk = ~clk;

  pwm_dac_driver #(.WIDTH(8), .PRESCALE(1)) dut0 (
    .clk(clk), .rst(rst), .din(d0), .din_valid(dv[0]), .din_ready(rdy[0]),
    .underrun_clr(clr[0]), .pwm_out(pwm[0]), .period_start(ps[0]), .underrun(ur[0])
  );
  pwm_dac_driver #(.WIDTH(4), .PRESCALE(3)) dut1 (
    .clk(clk), .rst(rst), .din(d1), .din_valid(dv[1]), .din_ready(rdy[1]),
    .underrun_clr(clr[1]), .pwm_out(pwm[1]), .period_start(ps[1]), .underrun(ur[1])
  );

  function automatic int wof(int i);
    return i == 0 ? 8 : 4;
  endfunction
  function automatic int pof(int i);
    return i == 0 ? 1 : 3;
  endfunction
  function automatic int plen(int i);
    return (1 << wof(i)) * pof(i);
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: position in the run (clocks since reset release) determines counter and boundary directly.
  always @(posedge clk or posedge rst) begin
    int cnt;
    bit bnd, xf;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_duty[i] = 0; m_hold[i] = 0; pos[i] = 0;
        m_full[i] = 0; m_under[i] = 0; m_pwm[i] = 0; m_ps[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        cnt = (pos[i] / pof(i)) % (1 << wof(i));
        bnd = ((pos[i] + 1) % plen(i)) == 0;
        xf = dv[i] && !m_full[i];
        m_pwm[i] = cnt < m_duty[i];
        m_ps[i] = bnd;
        m_under[i] = (bnd && !m_full[i]) || (m_under[i] && !clr[i]);
        if (bnd && m_full[i]) begin
          m_duty[i] = m_hold[i];
          m_full[i] = 0;
        end else if (xf) begin
          m_hold[i] = i == 0 ? int'(d0) : int'(d1);
          m_full[i] = 1;
        end
        pos[i]++;
      end
    end
  end

  always @(negedge clk)
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d pwm_out", i), pwm[i], m_pwm[i]);
      chk($sformatf("u%0d period_start", i), ps[i], m_ps[i]);
      chk($sformatf("u%0d underrun", i), ur[i], m_under[i]);
      chk($sformatf("u%0d din_ready", i), rdy[i], !m_full[i]);
    end

  task automatic setd(int i, int v);
    if (i == 0) d0 = 8'(v); else d1 = 4'(v);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(int i, int v);
    int k = 0;
    dv[i] = 1'b1;
    setd(i, v);
    while (!rdy[i] && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (k == 1000) chk("send timeout", 0, 1);
    @(negedge clk);
    dv[i] = 1'b0;
  endtask

  task automatic wait_ps(int i);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!ps[i] && k < 1000);
    if (!ps[i]) chk("period_start timeout", 0, 1);
  endtask

  // Counts pwm highs over one period starting at a period_start negedge; ends at the next one.
  task automatic measure(int i, int exp, bit wait_first, string nm);
    int hi = 0, first = -1, last = -1;
    if (wait_first) wait_ps(i);
    for (int j = 1; j <= plen(i); j++) begin
      @(negedge clk);
      if (pwm[i]) begin
        hi++;
        if (first < 0) first = j;
        last = j;
      end
    end
    chk({nm, " high count"}, hi, exp * pof(i));
    if (exp > 0) begin
      chk({nm, " first high"}, first, 1);
      chk({nm, " last high"}, last, exp * pof(i));
    end
    chk({nm, " period length"}, ps[i], 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    repeat (3) @(negedge clk);
    chk("reset pwm_out", pwm[0], 0);
    chk("reset period_start", ps[0], 0);
    chk("reset underrun", ur[0], 0);
    chk("reset din_ready", rdy[0], 1);
    rst = 1'b0;
    dv[0] = 1'b1;
    d0 = 8'd64;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) dv[0] = 1'b0;
    end while (!ps[0] && k < 1000);
    chk("first period_start clocks", k, 256);
    chk("no underrun at fed bnd", ur[0], 0);
    measure(0, 64, 0, "duty64");
    measure(0, 64, 0, "duty64 kept");
    chk("underrun after empty bnd", ur[0], 1);
    send(0, 0);
    measure(0, 0, 1, "duty0 p1");
    measure(0, 0, 0, "duty0 p2");
    measure(0, 0, 0, "duty0 p3");
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    chk("underrun cleared", ur[0], 0);
    send(0, 255);
    measure(0, 255, 1, "duty255");
    send(0, 32);
    dv[0] = 1'b1;
    d0 = 8'd200;
    k = 0;
    while (!rdy[0] && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("backpressure cycles", k, 255);
    chk("ready rises with period_start", ps[0], 1);
    measure(0, 32, 0, "bp duty32");
    dv[0] = 1'b0;
    measure(0, 200, 0, "bp duty200");
    repeat (255) @(negedge clk);
    dv[0] = 1'b1;
    d0 = 8'd77;
    @(negedge clk);
    dv[0] = 1'b0;
    chk("race bnd", ps[0], 1);
    chk("race sample held", rdy[0], 0);
    measure(0, 200, 0, "race current");
    measure(0, 77, 0, "race next");
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    chk("underrun cleared 2", ur[0], 0);
    send(0, 100);
    wait_ps(0);
    chk("fed bnd keeps underrun low", ur[0], 0);
    measure(0, 100, 0, "ur duty100");
    chk("underrun set", ur[0], 1);
    measure(0, 100, 0, "ur duty100 kept");
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    chk("underrun cleared 3", ur[0], 0);
    repeat (254) @(negedge clk);
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    chk("clr at bnd: bnd", ps[0], 1);
    chk("clr at bnd: set wins", ur[0], 1);
    wait_ps(1);
    send(1, 5);
    measure(1, 5, 1, "prescale duty5");
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      dv = 2'($urandom_range(0, 3));
      d0 = 8'($urandom);
      d1 = 4'($urandom);
      clr[0] = $urandom_range(0, 19) == 0;
      clr[1] = $urandom_range(0, 19) == 0;
    end
    @(negedge clk);
    dv = '0;
    clr = '0;
    wait_ps(0);
    send(0, 255);
    wait_ps(0);
    send(0, 9);
    repeat (5) @(negedge clk);
    chk("pre-reset pwm high", pwm[0], 1);
    chk("pre-reset hold full", rdy[0], 0);
    #2 rst = 1'b1;
    #1;
    chk("async reset pwm_out", pwm[0], 0);
    chk("async reset period_start", ps[0], 0);
    chk("async reset underrun", ur[0], 0);
    chk("async reset din_ready", rdy[0], 1);
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!ps[0] && k < 1000);
    chk("period_start after reset", k, 256);
    measure(0, 0, 0, "duty lost by reset");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule
